// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: one-bit-per-clock UART transmit framer.
// Frame = start(0), WIDTH_DATA data bits LSB first, optional parity, stop(1).
// A new frame may be accepted from IDLE or directly from STOP (no idle gap).
// TX_OUT and BUSY are registered and describe the state being entered, so
// the start bit appears in the cycle right after acceptance.
module uart_tx_ctrl #(
    parameter int WIDTH_DATA = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH_DATA-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int CNT_W = (WIDTH_DATA > 1) ? $clog2(WIDTH_DATA) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_DATA - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [WIDTH_DATA-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [WIDTH_DATA-1:0] data_r;
    logic [WIDTH_DATA-1:0] data_nxt_s;
    logic                  par_en_r;
    logic                  par_en_nxt_s;
    logic                  par_typ_r;
    logic                  par_typ_nxt_s;
    logic                  tx_out_r;
    logic                  tx_nxt_s;
    logic                  busy_r;
    logic                  accept_s;

    assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-state, latch and next-serial-bit decode; all outputs are derived
    // from the state being entered so they can be registered.
    always_comb begin
        accept_s      = DATA_VALID && ((state_r == ST_IDLE) || (state_r == ST_STOP));
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        data_nxt_s    = data_r;
        par_en_nxt_s  = par_en_r;
        par_typ_nxt_s = par_typ_r;
        tx_nxt_s      = 1'b1;
        case (state_r)
            ST_IDLE, ST_STOP: begin
                if (accept_s) begin
                    data_nxt_s    = P_DATA;
                    par_en_nxt_s  = PAR_EN;
                    par_typ_nxt_s = PAR_TYP;
                    state_nxt_s   = ST_START;
                    tx_nxt_s      = 1'b0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    tx_nxt_s      = 1'b1;
                end
            end
            ST_START: begin
                state_nxt_s = ST_DATA;
                cnt_nxt_s   = {CNT_W{1'b0}};
                tx_nxt_s    = data_r[0];
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                    if (par_en_r) begin
                        state_nxt_s = ST_PARITY;
                        tx_nxt_s    = calc_parity(data_r, par_typ_r);
                    end else begin
                        state_nxt_s = ST_STOP;
                        tx_nxt_s    = 1'b1;
                    end
                end else begin
                    cnt_nxt_s = cnt_inc_s;
                    tx_nxt_s  = data_r[cnt_inc_s];
                end
            end
            ST_PARITY: begin
                state_nxt_s = ST_STOP;
                tx_nxt_s    = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

    // State, counter, latches and registered outputs; reset aborts any frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            data_r    <= {WIDTH_DATA{1'b0}};
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            data_r    <= data_nxt_s;
            par_en_r  <= par_en_nxt_s;
            par_typ_r <= par_typ_nxt_s;
            tx_out_r  <= tx_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign TX_OUT = tx_out_r;
    assign BUSY   = busy_r;

endmodule
